// File: rtl/dense_layer_engine.sv
// dense_layer_engine: streaming fully-connected layer,
//   y[o] = act(sat((sum_i x[i]*W[o][i]) >>> WFRAC + b[o]))
// Ports:
//   clk, rst_n                  clock, async active-low reset
//   act_mode                    activation select, latched on the first input beat
//   in_data/in_valid/in_last    input vector stream; in_ready back-pressures it
//   w_addr/w_data               weight ROM (address o*N_IN+i, data ROM_LAT cycles later)
//   b_addr/b_data               bias ROM (address o)
//   out_data/out_valid/out_ready/out_last/out_idx   neuron result stream
//   busy                        vector in flight
//   len_err                     one-cycle pulse on an input length mismatch
module dense_layer_engine #(
  parameter int unsigned N_IN    = 3,
  parameter int unsigned N_OUT   = 9,
  parameter int unsigned DATA_W  = 16,
  parameter int unsigned W_W     = 8,
  parameter int unsigned WFRAC   = 7,
  parameter int unsigned DFRAC   = 8,
  parameter int unsigned ACC_W   = 32,
  parameter int unsigned ROM_LAT = 1,
  localparam int unsigned WA_W   = (N_IN * N_OUT > 1) ? $clog2(N_IN * N_OUT) : 1,
  localparam int unsigned OA_W   = (N_OUT > 1) ? $clog2(N_OUT) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [1:0]        act_mode,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  input  logic              in_last,
  output logic              in_ready,
  output logic [WA_W-1:0]   w_addr,
  input  logic [W_W-1:0]    w_data,
  output logic [OA_W-1:0]   b_addr,
  input  logic [DATA_W-1:0] b_data,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_last,
  output logic [OA_W-1:0]   out_idx,
  output logic              busy,
  output logic              len_err
);

  localparam int unsigned IA_W   = (N_IN > 1) ? $clog2(N_IN) : 1;
  localparam int unsigned WT_W   = $clog2(ROM_LAT + 1);
  localparam int unsigned PROD_W = DATA_W + W_W;

  localparam logic signed [ACC_W-1:0] SAT_HI = {{(ACC_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] SAT_LO = {{(ACC_W-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};
  localparam logic signed [DATA_W-1:0] TANH_HI = DATA_W'(1 << DFRAC);
  localparam logic signed [DATA_W-1:0] TANH_LO = -TANH_HI;

  typedef enum logic [3:0] {
    S_IDLE, S_LOAD, S_FETCH, S_WAIT, S_MAC,
    S_BIAS_FETCH, S_BIAS_WAIT, S_BIAS, S_EMIT
  } state_e;

  state_e                   state_q, state_d;
  logic signed [DATA_W-1:0] x_q [N_IN];
  logic signed [DATA_W-1:0] x_d [N_IN];
  logic [IA_W-1:0]          cnt_q, cnt_d;
  logic [IA_W-1:0]          i_q, i_d;
  logic [OA_W-1:0]          o_q, o_d;
  logic [WT_W-1:0]          wait_q, wait_d;
  logic signed [ACC_W-1:0]  acc_q, acc_d;
  logic [1:0]               mode_q, mode_d;
  logic                     in_ready_q, in_ready_d;
  logic [WA_W-1:0]          w_addr_q, w_addr_d;
  logic [OA_W-1:0]          b_addr_q, b_addr_d;
  logic [DATA_W-1:0]        out_data_q, out_data_d;
  logic                     out_valid_q, out_valid_d;
  logic                     out_last_q, out_last_d;
  logic [OA_W-1:0]          out_idx_q, out_idx_d;
  logic                     busy_q, busy_d;
  logic                     len_err_q, len_err_d;

  // MAC product and bias / saturation / activation datapath
  logic signed [PROD_W-1:0] prod;
  logic signed [ACC_W-1:0]  acc_sh;
  logic signed [ACC_W-1:0]  bias_sum;
  logic signed [DATA_W-1:0] sat_v;
  logic signed [DATA_W-1:0] act_v;

  assign prod     = PROD_W'($signed(x_q[i_q])) * PROD_W'($signed(w_data));
  assign acc_sh   = acc_q >>> WFRAC;
  assign bias_sum = acc_sh + ACC_W'($signed(b_data));

  always_comb begin
    if (bias_sum > SAT_HI)      sat_v = {1'b0, {(DATA_W-1){1'b1}}};
    else if (bias_sum < SAT_LO) sat_v = {1'b1, {(DATA_W-1){1'b0}}};
    else                        sat_v = bias_sum[DATA_W-1:0];
  end

  always_comb begin
    case (mode_q)
      2'd0:    act_v = sat_v;
      2'd1:    act_v = sat_v[DATA_W-1] ? {DATA_W{1'b0}} : sat_v;
      2'd2:    act_v = sat_v[DATA_W-1] ? (sat_v >>> 3) : sat_v;
      default: act_v = (sat_v > TANH_HI) ? TANH_HI :
                       ((sat_v < TANH_LO) ? TANH_LO : sat_v);
    endcase
  end

  // State and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      x_q         <= '{default: '0};
      cnt_q       <= '0;
      i_q         <= '0;
      o_q         <= '0;
      wait_q      <= '0;
      acc_q       <= '0;
      mode_q      <= '0;
      in_ready_q  <= 1'b1;
      w_addr_q    <= '0;
      b_addr_q    <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      out_idx_q   <= '0;
      busy_q      <= 1'b0;
      len_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      x_q         <= x_d;
      cnt_q       <= cnt_d;
      i_q         <= i_d;
      o_q         <= o_d;
      wait_q      <= wait_d;
      acc_q       <= acc_d;
      mode_q      <= mode_d;
      in_ready_q  <= in_ready_d;
      w_addr_q    <= w_addr_d;
      b_addr_q    <= b_addr_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
      out_idx_q   <= out_idx_d;
      busy_q      <= busy_d;
      len_err_q   <= len_err_d;
    end
  end

  // Next-state and registered-output logic
  always_comb begin
    state_d     = state_q;
    x_d         = x_q;
    cnt_d       = cnt_q;
    i_d         = i_q;
    o_d         = o_q;
    wait_d      = wait_q;
    acc_d       = acc_q;
    mode_d      = mode_q;
    in_ready_d  = in_ready_q;
    w_addr_d    = w_addr_q;
    b_addr_d    = b_addr_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    out_last_d  = out_last_q;
    out_idx_d   = out_idx_q;
    busy_d      = busy_q;
    len_err_d   = 1'b0;

    case (state_q)
      S_IDLE, S_LOAD: begin
        if (in_valid && in_ready_q) begin
          x_d[cnt_q] = in_data;
          if (state_q == S_IDLE) begin
            mode_d = act_mode;
            busy_d = 1'b1;
          end
          if (cnt_q == IA_W'(N_IN - 1)) begin
            // Full vector: a missing in_last is flagged but the vector is kept
            len_err_d  = !in_last;
            in_ready_d = 1'b0;
            cnt_d      = '0;
            o_d        = '0;
            i_d        = '0;
            acc_d      = '0;
            state_d    = S_FETCH;
          end else if (in_last) begin
            // Short vector: drop it and wait for a fresh one
            len_err_d = 1'b1;
            cnt_d     = '0;
            busy_d    = 1'b0;
            state_d   = S_IDLE;
          end else begin
            cnt_d   = cnt_q + IA_W'(1);
            state_d = S_LOAD;
          end
        end
      end

      S_FETCH: begin
        w_addr_d = WA_W'(32'(o_q) * N_IN + 32'(i_q));
        if (ROM_LAT > 1) begin
          wait_d  = WT_W'(ROM_LAT - 1);
          state_d = S_WAIT;
        end else begin
          state_d = S_MAC;
        end
      end

      S_WAIT: begin
        wait_d = wait_q - WT_W'(1);
        if (wait_q == WT_W'(1)) state_d = S_MAC;
      end

      S_MAC: begin
        acc_d = acc_q + ACC_W'(prod);
        if (i_q == IA_W'(N_IN - 1)) begin
          state_d = S_BIAS_FETCH;
        end else begin
          i_d     = i_q + IA_W'(1);
          state_d = S_FETCH;
        end
      end

      S_BIAS_FETCH: begin
        b_addr_d = o_q;
        if (ROM_LAT > 1) begin
          wait_d  = WT_W'(ROM_LAT - 1);
          state_d = S_BIAS_WAIT;
        end else begin
          state_d = S_BIAS;
        end
      end

      S_BIAS_WAIT: begin
        wait_d = wait_q - WT_W'(1);
        if (wait_q == WT_W'(1)) state_d = S_BIAS;
      end

      S_BIAS: begin
        out_data_d  = act_v;
        out_valid_d = 1'b1;
        out_idx_d   = o_q;
        out_last_d  = (o_q == OA_W'(N_OUT - 1));
        state_d     = S_EMIT;
      end

      S_EMIT: begin
        // Everything holds until the downstream stage takes the result
        if (out_ready) begin
          out_valid_d = 1'b0;
          out_last_d  = 1'b0;
          if (o_q == OA_W'(N_OUT - 1)) begin
            busy_d     = 1'b0;
            in_ready_d = 1'b1;
            state_d    = S_IDLE;
          end else begin
            o_d     = o_q + OA_W'(1);
            i_d     = '0;
            acc_d   = '0;
            state_d = S_FETCH;
          end
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  assign in_ready  = in_ready_q;
  assign w_addr    = w_addr_q;
  assign b_addr    = b_addr_q;
  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;
  assign out_last  = out_last_q;
  assign out_idx   = out_idx_q;
  assign busy      = busy_q;
  assign len_err   = len_err_q;

endmodule

// File: tb/tb_dense_layer_engine.sv
// Bench for dense_layer_engine: two engines (ROM_LAT=1 and ROM_LAT=3) share
// the input stream; expected neuron results are queued when a vector is issued
// and a negedge monitor pops and compares them on each output handshake.
module tb_dense_layer_engine;

  localparam int unsigned N_IN  = 2;
  localparam int unsigned N_OUT = 3;
  localparam int LAT1 = N_IN * (1 + 1) + 1 + 2;
  localparam int LAT3 = N_IN * (3 + 1) + 3 + 2;

  typedef struct {
    int data;
    int idx;
    bit last;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  act_mode;
  logic [15:0] in_data;
  logic        in_valid;
  logic        in_last;

  logic        in_ready_1, in_ready_3;
  logic [2:0]  wa_1, wa_3;
  logic [7:0]  wd_1, wd_3;
  logic [1:0]  ba_1, ba_3;
  logic [15:0] bd_1, bd_3;
  logic [15:0] od_1, od_3;
  logic        ov_1, ov_3;
  logic        ordy_1;
  logic        ordy_3;
  logic        ol_1, ol_3;
  logic [1:0]  oi_1, oi_3;
  logic        busy_1, busy_3;
  logic        le_1, le_3;

  logic signed [7:0]  w_rom [6];
  logic signed [15:0] b_rom [3];
  logic [2:0] wa3_p1, wa3_p2;
  logic [1:0] ba3_p1, ba3_p2;

  exp_t q1[$];
  exp_t q3[$];
  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;
  bit   pend   [2];
  int   cap_d  [2];
  int   cap_i  [2];
  bit   cap_l  [2];
  int   hs_cyc [2];
  bit   hs_ok  [2];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // ROM models: combinational for ROM_LAT=1, two address register stages for ROM_LAT=3
  assign wd_1 = w_rom[wa_1];
  assign bd_1 = b_rom[ba_1];
  always @(posedge clk) begin
    wa3_p1 <= wa_3;
    wa3_p2 <= wa3_p1;
    ba3_p1 <= ba_3;
    ba3_p2 <= ba3_p1;
  end
  assign wd_3   = w_rom[wa3_p2];
  assign bd_3   = b_rom[ba3_p2];
  assign ordy_3 = 1'b1;

  dense_layer_engine #(.N_IN(N_IN), .N_OUT(N_OUT), .ROM_LAT(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .act_mode(act_mode),
    .in_data(in_data), .in_valid(in_valid), .in_last(in_last), .in_ready(in_ready_1),
    .w_addr(wa_1), .w_data(wd_1), .b_addr(ba_1), .b_data(bd_1),
    .out_data(od_1), .out_valid(ov_1), .out_ready(ordy_1), .out_last(ol_1),
    .out_idx(oi_1), .busy(busy_1), .len_err(le_1)
  );

  dense_layer_engine #(.N_IN(N_IN), .N_OUT(N_OUT), .ROM_LAT(3)) u_dut3 (
    .clk(clk), .rst_n(rst_n), .act_mode(act_mode),
    .in_data(in_data), .in_valid(in_valid), .in_last(in_last), .in_ready(in_ready_3),
    .w_addr(wa_3), .w_data(wd_3), .b_addr(ba_3), .b_data(bd_3),
    .out_data(od_3), .out_valid(ov_3), .out_ready(ordy_3), .out_last(ol_3),
    .out_idx(oi_3), .busy(busy_3), .len_err(le_3)
  );

  function automatic int sx(logic [15:0] v);
    return int'($signed(v));
  endfunction

  task automatic chk(string name, int act, int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic fail(string name);
    total++;
    bad++;
    $display("FAIL %s: timed out (t=%0t)", name, $time);
  endtask

  // One monitor step for engine d; called on every falling edge
  task automatic mon_step(int d, logic v, logic r, logic [15:0] dat, logic [1:0] idx, logic last);
    exp_t e;
    bit   empty;
    if (!v) return;
    if (!pend[d]) begin
      pend[d]  = 1'b1;
      cap_d[d] = sx(dat);
      cap_i[d] = int'(idx);
      cap_l[d] = last;
      if (hs_ok[d]) chk($sformatf("latency_dut%0d", d), cyc - hs_cyc[d], (d == 0) ? LAT1 : LAT3);
    end else begin
      chk($sformatf("stable_data_dut%0d", d), sx(dat), cap_d[d]);
      chk($sformatf("stable_idx_dut%0d", d), int'(idx), cap_i[d]);
      chk($sformatf("stable_last_dut%0d", d), int'(last), int'(cap_l[d]));
    end
    if (r) begin
      empty = (d == 0) ? (q1.size() == 0) : (q3.size() == 0);
      if (empty) begin
        total++;
        bad++;
        $display("FAIL unexpected_out_dut%0d: got data=%0d idx=%0d, expected no output", d, sx(dat), idx);
      end else begin
        if (d == 0) e = q1.pop_front();
        else        e = q3.pop_front();
        chk($sformatf("out_data_dut%0d_idx%0d", d, e.idx), sx(dat), e.data);
        chk($sformatf("out_idx_dut%0d", d), int'(idx), e.idx);
        chk($sformatf("out_last_dut%0d_idx%0d", d, e.idx), int'(last), int'(e.last));
      end
      pend[d]   = 1'b0;
      hs_cyc[d] = cyc;
      hs_ok[d]  = !last;
    end
  endtask

  always @(negedge clk) begin
    if (!rst_n) begin
      for (int d = 0; d < 2; d++) begin
        pend[d]  = 1'b0;
        hs_ok[d] = 1'b0;
      end
    end else begin
      mon_step(0, ov_1, ordy_1, od_1, oi_1, ol_1);
      mon_step(1, ov_3, ordy_3, od_3, oi_3, ol_3);
    end
  end

  task automatic set_w(int w);
    for (int k = 0; k < 6; k++) w_rom[k] = 8'(w);
  endtask

  task automatic set_b(int b0, int b1, int b2);
    b_rom[0] = 16'(b0);
    b_rom[1] = 16'(b1);
    b_rom[2] = 16'(b2);
  endtask

  task automatic push3(int v0, int v1, int v2);
    exp_t e;
    int   v [3];
    v[0] = v0; v[1] = v1; v[2] = v2;
    for (int k = 0; k < 3; k++) begin
      e.data = v[k];
      e.idx  = k;
      e.last = (k == 2);
      q1.push_back(e);
      q3.push_back(e);
    end
  endtask

  task automatic check_rst(string tag);
    chk({tag, "_data1"}, int'(od_1), 0);   chk({tag, "_data3"}, int'(od_3), 0);
    chk({tag, "_valid1"}, int'(ov_1), 0);  chk({tag, "_valid3"}, int'(ov_3), 0);
    chk({tag, "_last1"}, int'(ol_1), 0);   chk({tag, "_last3"}, int'(ol_3), 0);
    chk({tag, "_idx1"}, int'(oi_1), 0);    chk({tag, "_idx3"}, int'(oi_3), 0);
    chk({tag, "_busy1"}, int'(busy_1), 0); chk({tag, "_busy3"}, int'(busy_3), 0);
    chk({tag, "_lenerr1"}, int'(le_1), 0); chk({tag, "_lenerr3"}, int'(le_3), 0);
    chk({tag, "_waddr1"}, int'(wa_1), 0);  chk({tag, "_waddr3"}, int'(wa_3), 0);
    chk({tag, "_baddr1"}, int'(ba_1), 0);  chk({tag, "_baddr3"}, int'(ba_3), 0);
    chk({tag, "_inready1"}, int'(in_ready_1), 1);
    chk({tag, "_inready3"}, int'(in_ready_3), 1);
  endtask

  // All waits below start and end at posedge+1
  task automatic wait_idle();
    int n = 0;
    while (!(in_ready_1 && in_ready_3 && !busy_1 && !busy_3) && n < 2000) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 2000) fail("wait_idle");
  endtask

  task automatic drain();
    int n = 0;
    while ((q1.size() != 0 || q3.size() != 0) && n < 3000) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 3000) fail("drain");
  endtask

  task automatic drive(int x0, int x1, int mode, int mode_after, bit last_ok);
    wait_idle();
    act_mode = 2'(mode);
    in_valid = 1'b1;
    in_data  = 16'(x0);
    in_last  = 1'b0;
    @(posedge clk); #1;
    act_mode = 2'(mode_after);
    in_data  = 16'(x1);
    in_last  = last_ok;
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
    chk("compute_inready1", int'(in_ready_1), 0);
    chk("compute_inready3", int'(in_ready_3), 0);
    chk("compute_busy1", int'(busy_1), 1);
    chk("compute_busy3", int'(busy_3), 1);
    chk("lenerr_final1", int'(le_1), int'(!last_ok));
    chk("lenerr_final3", int'(le_3), int'(!last_ok));
    act_mode = ~act_mode;
  endtask

  initial begin
    int n;
    rst_n    = 1'b0;
    act_mode = 2'd0;
    in_data  = '0;
    in_valid = 1'b0;
    in_last  = 1'b0;
    ordy_1   = 1'b1;
    set_w(64);
    set_b(0, 0, 0);
    repeat (3) @(posedge clk);
    #1 check_rst("reset");
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Basic MAC: 2*256*64 >>> 7 = 256
    push3(256, 256, 256);
    drive(256, 256, 0, 0, 1'b1);
    drain();

    // Hard tanh: raw +/-2032 clamps to +/-256
    set_w(127);
    push3(256, 256, 256);
    drive(1024, 1024, 3, 3, 1'b1);
    drain();
    push3(-256, -256, -256);
    drive(-1024, -1024, 3, 3, 1'b1);
    drain();

    // Saturation: 65022+100 -> 32767, -65023+100 -> -32768
    set_b(100, 100, 100);
    push3(32767, 32767, 32767);
    drive(32767, 32767, 0, 0, 1'b1);
    drain();
    push3(-32768, -32768, -32768);
    drive(-32767, -32767, 0, 0, 1'b1);
    drain();

    // Activations on r=-512; first run switches act_mode after the first beat
    set_w(64);
    set_b(0, 0, 0);
    push3(-64, -64, -64);
    drive(-512, -512, 2, 1, 1'b1);
    drain();
    push3(0, 0, 0);
    drive(-512, -512, 1, 1, 1'b1);
    drain();
    push3(-512, -512, -512);
    drive(-512, -512, 0, 0, 1'b1);
    drain();

    // Backpressure on idx 1 of the ROM_LAT=1 engine, distinct biases
    set_b(10, 20, 30);
    ordy_1 = 1'b0;
    push3(266, 276, 286);
    drive(256, 256, 0, 0, 1'b1);
    for (int k = 0; k < 3; k++) begin
      n = 0;
      while (!ov_1 && n < 500) begin
        @(posedge clk); #1;
        n++;
      end
      if (n >= 500) begin
        fail("bp_wait_valid");
        break;
      end
      if (oi_1 == 2'd1) begin
        repeat (20) begin
          @(posedge clk); #1;
          chk("bp_valid", int'(ov_1), 1);
          chk("bp_data", sx(od_1), 276);
          chk("bp_idx", int'(oi_1), 1);
          chk("bp_waddr", int'(wa_1), 3);
          chk("bp_baddr", int'(ba_1), 1);
        end
      end
      ordy_1 = 1'b1;
      @(posedge clk); #1;
      ordy_1 = 1'b0;
    end
    ordy_1 = 1'b1;
    drain();

    // Final beat without in_last: flagged, still processed
    set_b(0, 0, 0);
    push3(256, 256, 256);
    drive(256, 256, 0, 0, 1'b0);
    drain();

    // in_last on beat 0: vector dropped, no outputs
    wait_idle();
    in_valid = 1'b1;
    in_data  = 16'd256;
    in_last  = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
    chk("short_lenerr1", int'(le_1), 1);
    chk("short_lenerr3", int'(le_3), 1);
    chk("short_inready1", int'(in_ready_1), 1);
    chk("short_inready3", int'(in_ready_3), 1);
    chk("short_busy1", int'(busy_1), 0);
    chk("short_busy3", int'(busy_3), 0);
    @(posedge clk); #1;
    chk("short_pulse1", int'(le_1), 0);
    chk("short_pulse3", int'(le_3), 0);
    repeat (30) @(posedge clk);
    #1;
    chk("short_noout1", int'(ov_1), 0);
    chk("short_noout3", int'(ov_3), 0);

    // Reset during MAC of neuron 1, then a clean vector
    push3(256, 256, 256);
    drive(256, 256, 0, 0, 1'b1);
    n = 0;
    while (!(ov_1 && oi_1 == 2'd0) && n < 500) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 500) fail("rst_wait_idx0");
    @(posedge clk);
    @(posedge clk); #1;
    chk("mac_waddr", int'(wa_1), 2);
    #2 rst_n = 1'b0;
    q1.delete();
    q3.delete();
    #1 check_rst("midrst");
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    set_b(1, 2, 3);
    push3(257, 258, 259);
    drive(256, 256, 0, 0, 1'b1);
    drain();

    wait_idle();
    chk("queues_empty", q1.size() + q3.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

endmodule
